// File: rtl/horn_light_arbiter.sv
// rtl/horn_light_arbiter.sv - fixed-priority horn/light actuator arbiter with chirp and alarm timing
//
// Purpose: shares one horn/light actuator among lock chirps (1 chirp),
//   unlock chirps (2 chirps) and the alarm (continuous blink while
//   requested). Priority in IDLE: alarm > unlock > lock.
// Optional feature macro: HORN_MUTE_EN (adds the mute input, which blanks
//   the horn during chirps).
// Ports:
//   clk        in   system clock, rising edge
//   reset1     in   asynchronous active-low reset
//   lock_req   in   1-cycle pulse, request one chirp
//   unlock_req in   1-cycle pulse, request two chirps
//   alarm_req  in   level, alarm active while high
//   mute       in   (HORN_MUTE_EN only) force horn low in chirp states
//   horn       out  registered horn drive
//   lights     out  registered light drive
//   grant      out  owner: 00 none, 01 lock, 10 unlock, 11 alarm
//   busy       out  high whenever state != IDLE
//   done       out  1-cycle pulse when a lock/unlock sequence completes
module horn_light_arbiter #(
  parameter int CHIRP_CYC     = 3,
  parameter int GAP_CYC       = 2,
  parameter int ALARM_ON_CYC  = 4,
  parameter int ALARM_OFF_CYC = 4
) (
  input  logic       clk,
  input  logic       reset1,
  input  logic       lock_req,
  input  logic       unlock_req,
  input  logic       alarm_req,
`ifdef HORN_MUTE_EN
  input  logic       mute,
`endif
  output logic       horn,
  output logic       lights,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(CHIRP_CYC, GAP_CYC), max2(ALARM_ON_CYC, ALARM_OFF_CYC));
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] CHIRP_LD = CW'(CHIRP_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] AON_LD   = CW'(ALARM_ON_CYC - 1);
  localparam logic [CW-1:0] AOFF_LD  = CW'(ALARM_OFF_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHIRP_ON  = 3'd1,
    CHIRP_GAP = 3'd2,
    ALARM_ON  = 3'd3,
    ALARM_OFF = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;          // cycles left in the current state minus one
  logic          more, more_n;        // another chirp follows the current one
  logic          lock_p, lock_p_n;
  logic          unlock_p, unlock_p_n;
  logic [1:0]    grant_n;
  logic          done_n, horn_n, lights_n, on_n;
  logic          lock_eff, unlock_eff;

  always_ff @(posedge clk or negedge reset1) begin
    if (!reset1) begin
      state    <= IDLE;
      cnt      <= '0;
      more     <= 1'b0;
      lock_p   <= 1'b0;
      unlock_p <= 1'b0;
      grant    <= 2'b00;
      done     <= 1'b0;
      horn     <= 1'b0;
      lights   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      more     <= more_n;
      lock_p   <= lock_p_n;
      unlock_p <= unlock_p_n;
      grant    <= grant_n;
      done     <= done_n;
      horn     <= horn_n;
      lights   <= lights_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    more_n     = more;
    grant_n    = grant;
    done_n     = 1'b0;
    // A pulse arriving in IDLE is seen on the same edge, so it can start
    // immediately; the flag is then cleared below for the one that starts.
    lock_eff   = lock_p | lock_req;
    unlock_eff = unlock_p | unlock_req;
    lock_p_n   = lock_eff;
    unlock_p_n = unlock_eff;

    case (state)
      IDLE: begin
        grant_n = 2'b00;
        if (alarm_req) begin
          state_n = ALARM_ON;
          cnt_n   = AON_LD;
          grant_n = 2'b11;
        end else if (unlock_eff) begin
          state_n    = CHIRP_ON;
          cnt_n      = CHIRP_LD;
          more_n     = 1'b1;
          grant_n    = 2'b10;
          unlock_p_n = 1'b0;
        end else if (lock_eff) begin
          state_n  = CHIRP_ON;
          cnt_n    = CHIRP_LD;
          more_n   = 1'b0;
          grant_n  = 2'b01;
          lock_p_n = 1'b0;
        end
      end
      CHIRP_ON: begin
        if (alarm_req) begin
          state_n = ALARM_ON;
          cnt_n   = AON_LD;
          grant_n = 2'b11;
        end else if (cnt == '0) begin
          state_n = CHIRP_GAP;
          cnt_n   = GAP_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CHIRP_GAP: begin
        if (alarm_req) begin
          state_n = ALARM_ON;
          cnt_n   = AON_LD;
          grant_n = 2'b11;
        end else if (cnt == '0) begin
          if (more) begin
            state_n = CHIRP_ON;
            cnt_n   = CHIRP_LD;
            more_n  = 1'b0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            grant_n = 2'b00;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ALARM_ON: begin
        if (!alarm_req) begin
          state_n = IDLE;
          cnt_n   = '0;
          grant_n = 2'b00;
        end else if (cnt == '0) begin
          state_n = ALARM_OFF;
          cnt_n   = AOFF_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ALARM_OFF: begin
        if (!alarm_req) begin
          state_n = IDLE;
          cnt_n   = '0;
          grant_n = 2'b00;
        end else if (cnt == '0) begin
          state_n = ALARM_ON;
          cnt_n   = AON_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        grant_n = 2'b00;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    on_n     = (state_n == CHIRP_ON) || (state_n == ALARM_ON);
    lights_n = on_n;
`ifdef HORN_MUTE_EN
    horn_n   = on_n & ~(mute & (state_n == CHIRP_ON));
`else
    horn_n   = on_n;
`endif
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_horn_light_arbiter.sv
// tb/tb_horn_light_arbiter.sv - scoreboard bench for horn_light_arbiter with random stimulus
module tb_horn_light_arbiter;

  localparam int CHIRP = 3;
  localparam int GAP   = 2;
  localparam int AON   = 4;
  localparam int AOFF  = 4;
  localparam int P     = CHIRP + GAP;
  localparam int AP    = AON + AOFF;

  logic       clk = 1'b0;
  logic       reset1;
  logic       lock_req, unlock_req, alarm_req, mute;
  logic       horn, lights, busy, done;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  horn_light_arbiter #(
    .CHIRP_CYC(CHIRP), .GAP_CYC(GAP), .ALARM_ON_CYC(AON), .ALARM_OFF_CYC(AOFF)
  ) dut (
    .clk(clk),
    .reset1(reset1),
    .lock_req(lock_req),
    .unlock_req(unlock_req),
    .alarm_req(alarm_req),
`ifdef HORN_MUTE_EN
    .mute(mute),
`endif
    .horn(horn),
    .lights(lights),
    .grant(grant),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       horn;
    logic       lights;
    logic [1:0] grant;
    logic       busy;
    logic       done;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode 0 idle, 1 chirp sequence, 2 alarm; t counts
  // cycles since the sequence began, n is the chirp count of the sequence.
  int   m_mode, m_t, m_n;
  logic [1:0] m_own;
  logic m_lp, m_up;

`ifdef HORN_MUTE_EN
  localparam bit MUTE_ON = 1'b1;
`else
  localparam bit MUTE_ON = 1'b0;
`endif

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_n = 0; m_own = 2'b00; m_lp = 1'b0; m_up = 1'b0;
  endtask

  task automatic model_edge(input logic l, input logic u, input logic a, input logic m);
    logic el, eu, dn;
    exp_t e;
    el = m_lp | l;
    eu = m_up | u;
    m_lp = el;
    m_up = eu;
    dn = 1'b0;
    case (m_mode)
      0: begin
        if (a) begin
          m_mode = 2; m_t = 0;
        end else if (eu) begin
          m_mode = 1; m_own = 2'b10; m_n = 2; m_t = 0; m_up = 1'b0;
        end else if (el) begin
          m_mode = 1; m_own = 2'b01; m_n = 1; m_t = 0; m_lp = 1'b0;
        end
      end
      1: begin
        if (a) begin
          m_mode = 2; m_t = 0;
        end else begin
          m_t++;
          if (m_t == m_n * P) begin
            m_mode = 0; dn = 1'b1;
          end
        end
      end
      default: begin
        if (!a) m_mode = 0;
        else m_t++;
      end
    endcase
    e.cyc    = cyc;
    e.done   = dn;
    e.busy   = (m_mode != 0);
    e.grant  = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? m_own : 2'b11;
    e.lights = (m_mode == 1) ? ((m_t % P) < CHIRP) : (m_mode == 2) ? ((m_t % AP) < AON) : 1'b0;
    e.horn   = e.lights & ~(MUTE_ON & m & (m_mode == 1));
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want, input int c);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, c, got, want);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare it
  // against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("horn",   int'(horn),   int'(e.horn),   e.cyc);
        chk("lights", int'(lights), int'(e.lights), e.cyc);
        chk("grant",  int'(grant),  int'(e.grant),  e.cyc);
        chk("busy",   int'(busy),   int'(e.busy),   e.cyc);
        chk("done",   int'(done),   int'(e.done),   e.cyc);
      end
    end
  end

  task automatic step(input logic l, input logic u, input logic a, input logic m);
    @(negedge clk);
    #1;
    cyc++;
    lock_req = l; unlock_req = u; alarm_req = a; mute = m;
    model_edge(l, u, a, m);
  endtask

  task automatic idle(input int n, input logic a);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_horn"},   int'(horn),   0, cyc);
    chk({tag, "_lights"}, int'(lights), 0, cyc);
    chk({tag, "_grant"},  int'(grant),  0, cyc);
    chk({tag, "_busy"},   int'(busy),   0, cyc);
    chk({tag, "_done"},   int'(done),   0, cyc);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #1;
    lock_req = 1'b0; unlock_req = 1'b0; alarm_req = 1'b0; mute = 1'b0;
    reset1 = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check_zero("async_rst");
    repeat (2) @(negedge clk);
    #1;
    reset1 = 1'b1;
  endtask

  initial begin
    logic a_lvl;
    reset1 = 1'b0; lock_req = 1'b0; unlock_req = 1'b0; alarm_req = 1'b0; mute = 1'b0;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    #1 reset1 = 1'b1;

    // single lock chirp
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(8, 1'b0);
    // unlock double chirp
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(12, 1'b0);
    // simultaneous: unlock first, then lock after one idle cycle
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(20, 1'b0);
    // alarm pre-empts unlock in its second on-cycle
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(1, 1'b0); idle(12, 1'b1); idle(4, 1'b0);
    // lock pulses latched during an alarm are served afterwards
    idle(2, 1'b1); step(1'b1, 1'b0, 1'b1, 1'b0); idle(5, 1'b1); idle(10, 1'b0);
    // extra lock pulse while a lock is pending is dropped
    step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(22, 1'b0);
    // reset in the middle of a chirp, then a normal lock sequence
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(8, 1'b0);
    // muted chirp, then alarm with mute held
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b0);

    // randomized traffic
    a_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) a_lvl = ~a_lvl;
      if ($urandom_range(0, 599) == 0) do_reset();
      step(($urandom_range(0, 11) == 0), ($urandom_range(0, 13) == 0), a_lvl,
           ($urandom_range(0, 3) == 0));
    end
    idle(25, 1'b0);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cycle %0d got 1 expected 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
